// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle RV32 controller and its datapath.
// The controller drives the strobes and mux selects; the datapath supplies instruction fields and ALU flags.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero, N, V;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       retire, illegal;

  modport master (
    input  op, funct3, funct7b5, Zero, N, V,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, retire, illegal
  );

  modport slave (
    output op, funct3, funct7b5, Zero, N, V,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, retire, illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32 core: sequences fetch/decode/execute/memory/writeback
// and derives ALU control, immediate format and branch resolution from the instruction fields.
module multicycle_controller (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus
);
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] alu_op;
  logic       taken;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    alu_op           = 2'b00;
    taken            = 1'b0;
    bus.PCWrite      = 1'b0;
    bus.AdrSrc       = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.IRWrite      = 1'b0;
    bus.RegWrite     = 1'b0;
    bus.ResultSrc    = 2'b00;
    bus.ALUSrcA      = 2'b00;
    bus.ALUSrcB      = 2'b00;
    bus.retire       = 1'b0;
    bus.illegal      = 1'b0;
    case (state)
      FETCH: begin
        bus.IRWrite   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.PCWrite   = 1'b1;
        state_nxt     = DECODE;
      end
      DECODE: begin
        // OldPC + imm precomputes the branch/jump target into ALUOut
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_R:         state_nxt = EXECR;
          OP_I:         state_nxt = EXECI;
          OP_BR:        state_nxt = BRANCH;
          OP_JAL:       state_nxt = JAL;
          default: begin
            bus.illegal = 1'b1;
            state_nxt   = FETCH;
          end
        endcase
      end
      MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        state_nxt   = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        bus.AdrSrc = 1'b1;
        state_nxt  = MEMWB;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = 1'b1;
        bus.retire    = 1'b1;
        state_nxt     = FETCH;
      end
      MEMWRITE: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = 1'b1;
        bus.retire   = 1'b1;
        state_nxt    = FETCH;
      end
      EXECR: begin
        bus.ALUSrcA = 2'b10;
        alu_op      = 2'b10;
        state_nxt   = ALUWB;
      end
      EXECI: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        alu_op      = 2'b10;
        state_nxt   = ALUWB;
      end
      ALUWB: begin
        bus.RegWrite = 1'b1;
        bus.retire   = 1'b1;
        state_nxt    = FETCH;
      end
      BRANCH: begin
        bus.ALUSrcA = 2'b10;
        alu_op      = 2'b01;
        bus.retire  = 1'b1;
        case (bus.funct3)
          3'b000:  taken = bus.Zero;
          3'b001:  taken = !bus.Zero;
          3'b100:  taken = bus.N ^ bus.V;
          3'b101:  taken = !(bus.N ^ bus.V);
          default: taken = 1'b0;
        endcase
        bus.PCWrite = taken;
        state_nxt   = FETCH;
      end
      JAL: begin
        // PC takes the target now; ALUWB then writes PC+4 (from OldPC+4) into rd
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        bus.PCWrite = 1'b1;
        state_nxt   = ALUWB;
      end
      default: state_nxt = FETCH;
    endcase
    // Abandoned instructions must never leave a write behind
    if (reset) begin
      bus.PCWrite  = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.RegWrite = 1'b0;
      bus.MemWrite = 1'b0;
      bus.retire   = 1'b0;
      bus.illegal  = 1'b0;
    end
  end

  always_comb begin
    case (bus.op)
      OP_SW:   bus.ImmSrc = 2'b01;
      OP_BR:   bus.ImmSrc = 2'b10;
      OP_JAL:  bus.ImmSrc = 2'b11;
      default: bus.ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    bus.ALUControl = 3'b000;
    case (alu_op)
      2'b00: bus.ALUControl = 3'b000;
      2'b01: bus.ALUControl = 3'b001;
      default: begin
        case (bus.funct3)
          3'b000:  bus.ALUControl = (bus.op == OP_R && bus.funct7b5) ? 3'b001 : 3'b000;
          3'b001:  bus.ALUControl = 3'b101;
          3'b010:  bus.ALUControl = 3'b111;
          3'b011:  bus.ALUControl = 3'b111;
          3'b100:  bus.ALUControl = 3'b100;
          3'b101:  bus.ALUControl = 3'b110;
          3'b110:  bus.ALUControl = 3'b011;
          default: bus.ALUControl = 3'b010;
        endcase
      end
    endcase
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus random instruction streams
// checked cycle by cycle against a per-instruction timeline model.
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset;
  multicycle_controller_if bus ();
  multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit legal(input logic [6:0] op);
    return op == OP_LW || op == OP_SW || op == OP_R || op == OP_I || op == OP_BR || op == OP_JAL;
  endfunction

  // Total cycles an instruction occupies, FETCH included
  function automatic int latency(input logic [6:0] op);
    case (op)
      OP_LW:                      return 5;
      OP_SW, OP_R, OP_I, OP_JAL:  return 4;
      OP_BR:                      return 3;
      default:                    return 2;
    endcase
  endfunction

  function automatic logic [2:0] alu_expect(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    logic [2:0] tbl [8];
    tbl = '{3'b000, 3'b101, 3'b111, 3'b111, 3'b100, 3'b110, 3'b011, 3'b010};
    if (f3 == 3'b000 && op == OP_R && f7) return 3'b001;
    return tbl[f3];
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic n, input logic v);
    if (f3 == 3'b000) return z;
    if (f3 == 3'b001) return !z;
    if (f3 == 3'b100) return n != v;
    if (f3 == 3'b101) return n == v;
    return 1'b0;
  endfunction

  function automatic logic [1:0] imm_expect(input logic [6:0] op);
    if (op == OP_SW)  return 2'b01;
    if (op == OP_BR)  return 2'b10;
    if (op == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  // Runs cycles start_k..stop_k (stop_k=0 means to the end) of one instruction
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input int start_k, input int stop_k, input bit fixed, input logic [2:0] zvn);
    int  last;
    bit  is_alu;
    logic pcw, irw, rw, mw, ret, ill, adr;
    last   = (stop_k == 0) ? latency(op) : stop_k;
    is_alu = (op == OP_R || op == OP_I);
    for (int k = start_k; k <= last; k++) begin
      @(negedge clk);
      reset        = 1'b0;
      bus.op       = op;
      bus.funct3   = f3;
      bus.funct7b5 = f7;
      if (fixed) {bus.Zero, bus.N, bus.V} = zvn;
      else       {bus.Zero, bus.N, bus.V} = 3'($urandom);
      #1;
      pcw = (k == 1) || (op == OP_JAL && k == 3) ||
            (op == OP_BR && k == 3 && branch_taken(f3, bus.Zero, bus.N, bus.V));
      irw = (k == 1);
      rw  = (op == OP_LW && k == 5) || ((is_alu || op == OP_JAL) && k == 4);
      mw  = (op == OP_SW && k == 4);
      ret = legal(op) && k == latency(op);
      ill = !legal(op) && k == 2;
      adr = (op == OP_LW || op == OP_SW) && k == 4;
      chk($sformatf("strobes op=%b f3=%b k=%0d", op, f3, k),
          {1'b0, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.retire, bus.illegal, bus.AdrSrc},
          {1'b0, pcw, irw, rw, mw, ret, ill, adr});
      if (k == 1)
        chk("fetch_mux", {2'b0, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc}, {2'b0, 2'b00, 2'b10, 2'b10});
      if (k == 2) begin
        chk("decode_mux", {4'b0, bus.ALUSrcA, bus.ALUSrcB}, {4'b0, 2'b01, 2'b01});
        chk($sformatf("immsrc op=%b", op), {6'b0, bus.ImmSrc}, {6'b0, imm_expect(op)});
      end
      if (k == 3 && is_alu)
        chk($sformatf("aluctl op=%b f3=%b f7=%b", op, f3, f7), {5'b0, bus.ALUControl}, {5'b0, alu_expect(op, f3, f7)});
      if (k == 3 && op == OP_BR)
        chk("branch_aluctl", {5'b0, bus.ALUControl}, 8'd1);
      if (rw)
        chk($sformatf("resultsrc op=%b", op), {6'b0, bus.ResultSrc}, (op == OP_LW) ? 8'd1 : 8'd0);
    end
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1;
      {bus.Zero, bus.N, bus.V} = 3'($urandom);
      #1;
      chk("reset_strobes",
          {2'b0, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.retire, bus.illegal}, 8'h00);
    end
  endtask

  initial begin
    logic [6:0] ops [6];
    logic [6:0] op;
    reset        = 1'b1;
    bus.op       = OP_R;
    bus.funct3   = 3'b000;
    bus.funct7b5 = 1'b0;
    {bus.Zero, bus.N, bus.V} = 3'b000;
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL};

    reset_cycles(2);

    // Reset mid-EXECR, then the restarted stream begins in FETCH
    run_instr(OP_R, 3'b000, 1'b1, 1, 3, 1'b0, 3'b000);
    reset_cycles(3);
    run_instr(OP_R, 3'b110, 1'b0, 1, 0, 1'b0, 3'b000);

    // Directed: lw, sub vs addi, branch flag combinations, jal, illegal
    run_instr(OP_LW,  3'b010, 1'b0, 1, 0, 1'b0, 3'b000);
    run_instr(OP_R,   3'b000, 1'b1, 1, 0, 1'b0, 3'b000);
    run_instr(OP_I,   3'b000, 1'b1, 1, 0, 1'b0, 3'b000);
    run_instr(OP_BR,  3'b100, 1'b0, 1, 0, 1'b1, 3'b010);
    run_instr(OP_BR,  3'b100, 1'b0, 1, 0, 1'b1, 3'b011);
    run_instr(OP_BR,  3'b000, 1'b0, 1, 0, 1'b1, 3'b000);
    run_instr(OP_BR,  3'b000, 1'b0, 1, 0, 1'b1, 3'b100);
    run_instr(OP_BR,  3'b101, 1'b0, 1, 0, 1'b1, 3'b011);
    run_instr(OP_BR,  3'b010, 1'b0, 1, 0, 1'b1, 3'b100);
    run_instr(OP_JAL, 3'b000, 1'b0, 1, 0, 1'b0, 3'b000);
    run_instr(OP_SW,  3'b010, 1'b0, 1, 0, 1'b0, 3'b000);
    run_instr(7'b1111111, 3'b000, 1'b0, 1, 0, 1'b0, 3'b000);
    run_instr(OP_R,   3'b101, 1'b1, 1, 0, 1'b0, 3'b000);

    // Random instruction stream with random flags every cycle
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 6) == 0) begin
        do op = 7'($urandom); while (legal(op));
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      run_instr(op, 3'($urandom), 1'($urandom), 1, 0, 1'b0, 3'b000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
